// File: rtl/quad_counter_ctrl.sv
// Quadrature encoder position counter: per-channel sync and glitch filter,
// Gray-code decode with x1/x2/x4 qualification, bounded wrap/saturate count.
module quad_counter_ctrl #(
  parameter int N          = 7,
  parameter int MIN_COUNT  = 0,
  parameter int MAX_COUNT  = 100,
  parameter int FILTER_LEN = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         canalA,
  input  logic         canalB,
  input  logic         sw,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         wrap_en,
  input  logic [1:0]   res_sel,
  output logic [N-1:0] contador_out,
  output logic         dir,
  output logic         step_pulse,
  output logic         at_min,
  output logic         at_max,
  output logic         err
);

  // state    | meaning
  // ST_INIT  | wait for sync/filter to settle, then latch filtered {A,B}
  // ST_TRACK | decode filtered {A,B} against previous state every cycle

  localparam logic [N-1:0] MIN_V = N'(MIN_COUNT);
  localparam logic [N-1:0] MAX_V = N'(MAX_COUNT);
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0] STABLE_TC = FW'(FILTER_LEN - 1);

  typedef enum logic {ST_INIT, ST_TRACK} state_t;

  logic [1:0]    sync1, sync2, filt;
  logic [FW-1:0] stab [2];

  state_t     state, state_nxt;
  logic [1:0] prev, prev_nxt;
  logic [1:0] init_tmr, init_tmr_nxt;
  logic       ev_valid, ev_valid_nxt;
  logic       ev_pos, ev_pos_nxt;
  logic       ev_illegal, ev_illegal_nxt;
  logic       settled, qualify;
  logic [N-1:0] load_clamped;

  function automatic logic [1:0] gray_idx(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= {canalA, canalB};
      sync2 <= sync1;
    end
  end

  // Any sample equal to the accepted level restarts that channel's run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 2'b00;
      for (int i = 0; i < 2; i++) stab[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          stab[i] <= '0;
        end else if (stab[i] == STABLE_TC) begin
          filt[i] <= sync2[i];
          stab[i] <= '0;
        end else begin
          stab[i] <= stab[i] + FW'(1);
        end
      end
    end
  end

  // INIT holds until the pins have propagated through the synchroniser and
  // filter, so an encoder resting away from 00 is not seen as a jump.
  assign settled = (sync1 == sync2) && (sync2 == filt);

  always_comb begin
    case (res_sel)
      2'b00:   qualify = (filt == 2'b00);
      2'b01:   qualify = (filt == 2'b00) || (filt == 2'b11);
      default: qualify = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      prev       <= 2'b00;
      init_tmr   <= 2'd2;
      ev_valid   <= 1'b0;
      ev_pos     <= 1'b0;
      ev_illegal <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev       <= prev_nxt;
      init_tmr   <= init_tmr_nxt;
      ev_valid   <= ev_valid_nxt;
      ev_pos     <= ev_pos_nxt;
      ev_illegal <= ev_illegal_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    prev_nxt       = prev;
    init_tmr_nxt   = init_tmr;
    ev_valid_nxt   = 1'b0;
    ev_pos_nxt     = 1'b0;
    ev_illegal_nxt = 1'b0;
    case (state)
      ST_INIT: begin
        if (init_tmr != 2'd0) begin
          init_tmr_nxt = init_tmr - 2'd1;
        end else if (settled) begin
          prev_nxt  = filt;
          state_nxt = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (filt != prev) begin
          prev_nxt = filt;
          if ((filt ^ prev) == 2'b11) begin
            ev_illegal_nxt = 1'b1;
          end else if (qualify) begin
            ev_valid_nxt = 1'b1;
            ev_pos_nxt   = (gray_idx(filt) == gray_idx(prev) + 2'd1);
          end
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    load_clamped = load_val;
    if (int'(load_val) < MIN_COUNT)
      load_clamped = MIN_V;
    else if (int'(load_val) > MAX_COUNT)
      load_clamped = MAX_V;
  end

  // Decoded events land one cycle after the filter so the count update
  // sits at a fixed FILTER_LEN+3 cycles from the first sampling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contador_out <= MIN_V;
      dir          <= 1'b0;
      step_pulse   <= 1'b0;
      err          <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (sw) begin
        contador_out <= MIN_V;
        err          <= 1'b0;
      end else begin
        if (ev_illegal) err <= 1'b1;
        if (load) begin
          contador_out <= load_clamped;
        end else if (ev_valid) begin
          if (ev_pos) begin
            if (contador_out != MAX_V) begin
              contador_out <= contador_out + N'(1);
              step_pulse   <= 1'b1;
              dir          <= 1'b1;
            end else if (wrap_en) begin
              contador_out <= MIN_V;
              step_pulse   <= 1'b1;
              dir          <= 1'b1;
            end
          end else begin
            if (contador_out != MIN_V) begin
              contador_out <= contador_out - N'(1);
              step_pulse   <= 1'b1;
              dir          <= 1'b0;
            end else if (wrap_en) begin
              contador_out <= MAX_V;
              step_pulse   <= 1'b1;
              dir          <= 1'b0;
            end
          end
        end
      end
    end
  end

  assign at_min = (contador_out == MIN_V);
  assign at_max = (contador_out == MAX_V);

endmodule
